wb_sched: RTL and testbench

WB_SCHED -- requirements
Module: wb_sched

---
 rtl/wb_sched.sv | 122 ++++++++++++
 tb/tb_wb_sched.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/wb_sched.sv
// Writeback scheduler: round-robin merge of EXU/LSU writeback packets into one registered
// register-file port, plus a per-GPR pending-write scoreboard that drives the issue stall.
module wb_sched #(
  parameter bit SB_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        a_valid_i,
  input  logic [72:0] a_pkt_i,
  output logic        a_ready_o,
  input  logic        b_valid_i,
  input  logic [72:0] b_pkt_i,
  output logic        b_ready_o,
  output logic        wb_valid_o,
  output logic [72:0] wb_pkt_o,
  output logic        wb_src_o,
  input  logic        iss_valid_i,
  input  logic [4:0]  iss_rd_i,
  input  logic        iss_reg_en_i,
  input  logic [4:0]  chk_rs1_i,
  input  logic [4:0]  chk_rs2_i,
  output logic        hazard_o,
  output logic        sb_err_o
);

  logic        last_b_q;  // B granted most recently, so A wins the next contention
  logic        grant_a, grant_b;
  logic [72:0] sel_pkt;
  logic        wb_valid_q, wb_src_q;
  logic [72:0] wb_pkt_q;
  logic [1:0]  cnt_q [32];
  logic [1:0]  cnt_d [32];
  logic        sb_err_q, sb_err_d;
  logic        iss_inc, cmt_dec;
  logic [4:0]  cmt_rd;

  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (!rst) begin
      if (a_valid_i && b_valid_i) begin
        grant_a = last_b_q;
        grant_b = !last_b_q;
      end else begin
        grant_a = a_valid_i;
        grant_b = b_valid_i;
      end
    end
  end

  // x0 is hardwired, so a write to it is demoted to a no-write.
  always_comb begin
    sel_pkt = grant_b ? b_pkt_i : a_pkt_i;
    if (sel_pkt[72] && (sel_pkt[71:67] == 5'd0)) sel_pkt[72] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_b_q   <= 1'b1;
      wb_valid_q <= 1'b0;
      wb_pkt_q   <= '0;
      wb_src_q   <= 1'b0;
    end else begin
      wb_valid_q <= grant_a || grant_b;
      if (grant_a || grant_b) begin
        wb_pkt_q <= sel_pkt;
        wb_src_q <= grant_b;
        last_b_q <= grant_b;
      end
    end
  end

  assign iss_inc = iss_valid_i && iss_reg_en_i && (iss_rd_i != 5'd0);
  assign cmt_dec = wb_valid_q && wb_pkt_q[72];
  assign cmt_rd  = wb_pkt_q[71:67];

  always_comb begin
    cnt_d    = cnt_q;
    sb_err_d = sb_err_q;
    cnt_d[0] = 2'd0;
    for (int i = 1; i < 32; i++) begin
      case ({iss_inc && (iss_rd_i == 5'(i)), cmt_dec && (cmt_rd == 5'(i))})
        2'b10: begin
          if (cnt_q[i] == 2'd3) sb_err_d = 1'b1;
          else cnt_d[i] = cnt_q[i] + 2'd1;
        end
        2'b01: begin
          if (cnt_q[i] == 2'd0) sb_err_d = 1'b1;
          else cnt_d[i] = cnt_q[i] - 2'd1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) cnt_q[i] <= 2'd0;
      sb_err_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      sb_err_q <= sb_err_d;
    end
  end

  // Stall looks at current counters only; a commit landing this cycle does not clear it early.
  always_comb begin
    hazard_o = 1'b0;
    if (SB_EN) begin
      hazard_o = (cnt_q[chk_rs1_i] != 2'd0) || (cnt_q[chk_rs2_i] != 2'd0) ||
                 (iss_reg_en_i && (cnt_q[iss_rd_i] == 2'd3));
    end
  end

  assign sb_err_o   = SB_EN && sb_err_q;
  assign a_ready_o  = grant_a;
  assign b_ready_o  = grant_b;
  assign wb_valid_o = wb_valid_q;
  assign wb_pkt_o   = wb_pkt_q;
  assign wb_src_o   = wb_src_q;

endmodule

// File: tb/tb_wb_sched.sv
// Random and directed bench for wb_sched against a cycle-level behavioural model.
module tb_wb_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_valid, b_valid, a_ready, b_ready;
  logic [72:0] a_pkt, b_pkt, wb_pkt;
  logic        wb_valid, wb_src;
  logic        iss_valid, iss_reg_en;
  logic [4:0]  iss_rd, chk_rs1, chk_rs2;
  logic        hazard, sb_err;

  int n_cmp = 0;
  int n_err = 0;

  // Model state
  int          m_cnt [32];
  int          m_last;   // 0 = A granted last, 1 = B granted last
  bit          m_valid, m_src, m_err;
  logic [72:0] m_pkt;

  wb_sched dut (
    .clk         (clk),
    .rst         (rst),
    .a_valid_i   (a_valid),
    .a_pkt_i     (a_pkt),
    .a_ready_o   (a_ready),
    .b_valid_i   (b_valid),
    .b_pkt_i     (b_pkt),
    .b_ready_o   (b_ready),
    .wb_valid_o  (wb_valid),
    .wb_pkt_o    (wb_pkt),
    .wb_src_o    (wb_src),
    .iss_valid_i (iss_valid),
    .iss_rd_i    (iss_rd),
    .iss_reg_en_i(iss_reg_en),
    .chk_rs1_i   (chk_rs1),
    .chk_rs2_i   (chk_rs2),
    .hazard_o    (hazard),
    .sb_err_o    (sb_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [72:0] got, input logic [72:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [72:0] mk(input logic re, input logic [4:0] rd, input logic [31:0] wd);
    return {re, rd, wd, 1'b0, 2'b00, 32'h0};
  endfunction

  function automatic logic [72:0] rnd_pkt();
    return {1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom(),
            1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom()};
  endfunction

  // One clock: drive on the falling edge, check mid-low-phase, advance the model on the rising edge.
  task automatic step(input logic r, input logic av, input logic [72:0] ap,
                      input logic bv, input logic [72:0] bp, input logic iv, input logic ien,
                      input logic [4:0] ird, input logic [4:0] r1, input logic [4:0] r2);
    int win;
    bit haz, commit, issue;
    int crd;
    logic [72:0] p;
    @(negedge clk);
    rst = r; a_valid = av; a_pkt = ap; b_valid = bv; b_pkt = bp;
    iss_valid = iv; iss_reg_en = ien; iss_rd = ird; chk_rs1 = r1; chk_rs2 = r2;
    #1;
    if (r) win = -1;
    else if (av && bv) win = 1 - m_last;
    else if (av) win = 0;
    else if (bv) win = 1;
    else win = -1;
    haz = (m_cnt[r1] > 0) || (m_cnt[r2] > 0) || (ien && m_cnt[ird] == 3);
    check("a_ready", 73'(a_ready), 73'(win == 0));
    check("b_ready", 73'(b_ready), 73'(win == 1));
    check("hazard", 73'(hazard), 73'(haz));
    check("wb_valid", 73'(wb_valid), 73'(m_valid));
    check("wb_pkt", wb_pkt, m_pkt);
    check("sb_err", 73'(sb_err), 73'(m_err));
    if (m_valid) check("wb_src", 73'(wb_src), 73'(m_src));
    @(posedge clk);
    if (r) begin
      foreach (m_cnt[i]) m_cnt[i] = 0;
      m_last = 1; m_valid = 0; m_src = 0; m_err = 0; m_pkt = '0;
    end else begin
      commit = m_valid && m_pkt[72];
      crd    = int'(m_pkt[71:67]);
      issue  = iv && ien && ird != 5'd0;
      if (!(issue && commit && int'(ird) == crd)) begin
        if (issue) begin
          if (m_cnt[ird] + 1 > 3) m_err = 1;
          else m_cnt[ird] = m_cnt[ird] + 1;
        end
        if (commit) begin
          if (m_cnt[crd] - 1 < 0) m_err = 1;
          else m_cnt[crd] = m_cnt[crd] - 1;
        end
      end
      m_valid = (win >= 0);
      if (win >= 0) begin
        p = (win == 1) ? bp : ap;
        if (p[71:67] == 5'd0) p[72] = 1'b0;
        m_pkt  = p;
        m_src  = (win == 1);
        m_last = win;
      end
    end
  endtask

  task automatic idle(input logic [4:0] r1);
    step(1'b0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 5'd0, r1, 5'd0);
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    step(1'b1, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
  endtask

  initial begin
    logic [72:0] pa, pb;
    foreach (m_cnt[i]) m_cnt[i] = 0;
    m_last = 1; m_valid = 0; m_src = 0; m_err = 0; m_pkt = '0;
    rst = 1'b1; a_valid = 0; b_valid = 0; a_pkt = '0; b_pkt = '0;
    iss_valid = 0; iss_reg_en = 0; iss_rd = '0; chk_rs1 = '0; chk_rs2 = '0;

    do_reset();
    #2;
    check("rst_wb_valid", 73'(wb_valid), 73'(0));
    check("rst_wb_pkt", wb_pkt, '0);

    // Sustained contention alternates A,B,A,B
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, mk(1'b0, 5'd1, 32'h11), 1'b1, mk(1'b0, 5'd2, 32'h22),
           1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
      #2;
      check("rr_src", 73'(wb_src), 73'(i % 2));
      check("rr_valid", 73'(wb_valid), 73'(1));
    end

    // LSU-only packet
    step(1'b0, 1'b0, '0, 1'b1, mk(1'b1, 5'd5, 32'hDEADBEEF), 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    #2;
    check("b_only_valid", 73'(wb_valid), 73'(1));
    check("b_only_pkt", wb_pkt, mk(1'b1, 5'd5, 32'hDEADBEEF));
    check("b_only_src", 73'(wb_src), 73'(1));
    idle(5'd0);
    #2;
    check("hold_valid", 73'(wb_valid), 73'(0));
    check("hold_pkt", wb_pkt, mk(1'b1, 5'd5, 32'hDEADBEEF));

    // Two issues to x7, then two commits
    do_reset();
    step(1'b0, 1'b0, '0, 1'b0, '0, 1'b1, 1'b1, 5'd7, 5'd7, 5'd0);
    step(1'b0, 1'b0, '0, 1'b0, '0, 1'b1, 1'b1, 5'd7, 5'd7, 5'd0);
    #2;
    check("haz_pending", 73'(hazard), 73'(1));
    step(1'b0, 1'b1, mk(1'b1, 5'd7, 32'h1), 1'b0, '0, 1'b0, 1'b0, 5'd0, 5'd7, 5'd0);
    step(1'b0, 1'b1, mk(1'b1, 5'd7, 32'h2), 1'b0, '0, 1'b0, 1'b0, 5'd0, 5'd7, 5'd0);
    #2;
    check("haz_one_left", 73'(hazard), 73'(1));
    idle(5'd7);
    #2;
    check("haz_cleared", 73'(hazard), 73'(0));

    // Write to x0 is demoted
    step(1'b0, 1'b1, mk(1'b1, 5'd0, 32'h55), 1'b0, '0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    #2;
    check("x0_reg_en", 73'(wb_pkt[72]), 73'(0));
    check("x0_wd", 73'(wb_pkt[66:35]), 73'(32'h55));
    idle(5'd0);
    #2;
    check("x0_no_err", 73'(sb_err), 73'(0));

    // Commit with nothing pending
    step(1'b0, 1'b1, mk(1'b1, 5'd3, 32'h3), 1'b0, '0, 1'b0, 1'b0, 5'd0, 5'd3, 5'd0);
    idle(5'd3);
    #2;
    check("underflow_err", 73'(sb_err), 73'(1));
    check("underflow_cnt", 73'(hazard), 73'(0));
    idle(5'd3);
    idle(5'd3);
    #2;
    check("err_sticky", 73'(sb_err), 73'(1));

    // Reset the cycle after a grant
    step(1'b0, 1'b1, mk(1'b1, 5'd9, 32'h9), 1'b1, mk(1'b1, 5'd9, 32'h9),
         1'b1, 1'b1, 5'd9, 5'd9, 5'd0);
    step(1'b1, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 5'd0, 5'd9, 5'd0);
    #2;
    check("rst_mid_valid", 73'(wb_valid), 73'(0));
    check("rst_mid_haz", 73'(hazard), 73'(0));
    check("rst_mid_err", 73'(sb_err), 73'(0));
    step(1'b0, 1'b1, mk(1'b0, 5'd1, 32'h1), 1'b1, mk(1'b0, 5'd2, 32'h2),
         1'b0, 1'b0, 5'd0, 5'd9, 5'd0);
    #2;
    check("rst_first_a", 73'(wb_src), 73'(0));

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      pa = rnd_pkt();
      pb = rnd_pkt();
      step(1'($urandom_range(0, 49) == 0), 1'($urandom_range(0, 1)), pa,
           1'($urandom_range(0, 1)), pb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
